// File: rtl/pi_pkg.sv
// Shared definitions for the priority-interrupt arbiter: FSM states, CONO PI
// control bit positions, CONI PI field positions and a level decoder.
package pi_pkg;

    typedef enum logic [0:0] {
        PI_IDLE = 1'b0,
        PI_REQ  = 1'b1
    } pi_state_t;

    // CONO PI control bits (PDP-10 numbering, bit 35 = LSB)
    localparam int CONO_DROP_PROG = 22;
    localparam int CONO_CLR       = 23;
    localparam int CONO_INIT      = 24;
    localparam int CONO_LVL_ON    = 25;
    localparam int CONO_LVL_OFF   = 26;
    localparam int CONO_SYS_OFF   = 27;
    localparam int CONO_SYS_ON    = 28;
    // Level l (1..7) of a CONO level mask sits at bit CONO_LVL_BASE + l
    localparam int CONO_LVL_BASE  = 28;

    // CONI PI field positions; level fields place level l at BASE + l
    localparam int CONI_TIMEOUT   = 0;
    localparam int CONI_PROG_BASE = 10;
    localparam int CONI_HELD_BASE = 20;
    localparam int CONI_ON        = 28;
    localparam int CONI_ACT_BASE  = 28;

    // One-hot [1:7] mask for a level number; level 0 yields an empty mask
    function automatic logic [1:7] lvl_onehot(input logic [2:0] lvl);
        logic [1:7] mask;
        mask = '0;
        for (int l = 1; l <= 7; l++) begin
            if (lvl == 3'(l)) begin
                mask[l] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/pi_prio_enc.sv
// Priority encoder over PI levels: returns the number of the lowest-numbered
// (highest-priority) set level, or 0 when no level is set.
module pi_prio_enc (
    input  logic [1:7] in_vec,
    output logic [2:0] idx
);

    // Scan from the lowest priority upward so the highest priority wins last
    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 1; i--) begin
            if (in_vec[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/pi_arb.sv
// Priority-interrupt arbiter. Merges APR, EBUS device and program requests
// into a single level-tagged request to the EBOX, tracks the on/active/held/
// program-request state set by CONO PI and presents it as the CONI PI word.
import pi_pkg::*;

module pi_arb #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic         apr_interrupt,
    input  logic [2:0]   apr_pia,
    input  logic [1:7]   dev_req,
    input  logic         cono_pi,
    input  logic [18:35] ebus_data,
    input  logic         pi_ack,
    input  logic         pi_dismiss,
    output logic         pi_req,
    output logic [2:0]   pi_lvl,
    output logic         pi_timeout,
    output logic [0:35]  coni_pi
);

    pi_state_t  state;
    logic [4:0] cnt;
    logic       sys_on;
    logic [1:7] active;
    logic [1:7] held;
    logic [1:7] prog;

    logic [1:7] req;
    logic [1:7] elig;
    logic       blocked;
    logic [2:0] win_lvl;
    logic [2:0] dis_lvl;

    logic [1:7] cono_lvl;
    logic       cono_clr;
    logic       on_nxt;
    logic [1:7] active_nxt;
    logic [1:7] prog_nxt;
    logic [1:7] held_nxt;
    logic       lvl_live;

    // Bits 18..21 of the CONO word carry no PI function
    logic unused_ebus;
    assign unused_ebus = &{1'b0, ebus_data[18:21]};

    assign cono_lvl = ebus_data[29:35];
    assign cono_clr = cono_pi & ebus_data[CONO_CLR];

    // Merge request sources and mask by enable, activation and held levels;
    // a held level blocks itself and every lower priority
    always_comb begin
        req     = '0;
        elig    = '0;
        blocked = 1'b0;
        for (int l = 1; l <= 7; l++) begin
            req[l]  = dev_req[l] | prog[l] | (apr_interrupt && (apr_pia == 3'(l)));
            blocked = blocked | held[l];
            elig[l] = sys_on & active[l] & req[l] & ~blocked;
        end
    end

    pi_prio_enc u_win_enc (
        .in_vec (elig),
        .idx    (win_lvl)
    );

    pi_prio_enc u_dis_enc (
        .in_vec (held),
        .idx    (dis_lvl)
    );

    // CONO PI effect on enable, activation and program requests; when a
    // set and a clear of the same thing coincide, the clear wins
    always_comb begin
        on_nxt     = sys_on;
        active_nxt = active;
        prog_nxt   = prog;
        if (cono_pi) begin
            if (ebus_data[CONO_INIT]) begin
                prog_nxt = prog_nxt | cono_lvl;
            end
            if (ebus_data[CONO_DROP_PROG]) begin
                prog_nxt = prog_nxt & ~cono_lvl;
            end
            if (ebus_data[CONO_LVL_ON]) begin
                active_nxt = active_nxt | cono_lvl;
            end
            if (ebus_data[CONO_LVL_OFF]) begin
                active_nxt = active_nxt & ~cono_lvl;
            end
            if (ebus_data[CONO_SYS_ON]) begin
                on_nxt = 1'b1;
            end
            if (ebus_data[CONO_SYS_OFF]) begin
                on_nxt = 1'b0;
            end
        end
    end

    // Dismiss acts on the held set as it stood, then an acknowledge adds its level
    always_comb begin
        held_nxt = held;
        if (pi_dismiss) begin
            held_nxt = held_nxt & ~lvl_onehot(dis_lvl);
        end
        if ((state == PI_REQ) && pi_ack) begin
            held_nxt = held_nxt | lvl_onehot(pi_lvl);
        end
    end

    // A pending request survives only while PI stays on and its level stays active
    assign lvl_live = on_nxt & (|(active_nxt & lvl_onehot(pi_lvl)));

    // PI system state registers, cleared by reset or CONO clear
    always_ff @(posedge clk) begin
        if (RESET || cono_clr) begin
            sys_on <= 1'b0;
            active <= '0;
            held   <= '0;
            prog   <= '0;
        end else begin
            sys_on <= on_nxt;
            active <= active_nxt;
            held   <= held_nxt;
            prog   <= prog_nxt;
        end
    end

    // Request handshake FSM: latch the winner, hold it until ack, abort or timeout
    always_ff @(posedge clk) begin
        if (RESET || cono_clr) begin
            state      <= PI_IDLE;
            pi_lvl     <= 3'd0;
            cnt        <= 5'd0;
            pi_timeout <= 1'b0;
        end else begin
            case (state)
                PI_IDLE: begin
                    if (win_lvl != 3'd0) begin
                        state  <= PI_REQ;
                        pi_lvl <= win_lvl;
                        cnt    <= 5'd0;
                    end
                end
                PI_REQ: begin
                    if (pi_ack) begin
                        state  <= PI_IDLE;
                        pi_lvl <= 3'd0;
                    end else if (!lvl_live) begin
                        state  <= PI_IDLE;
                        pi_lvl <= 3'd0;
                    end else if (cnt == 5'(ACK_TIMEOUT - 1)) begin
                        state      <= PI_IDLE;
                        pi_lvl     <= 3'd0;
                        pi_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: begin
                    state  <= PI_IDLE;
                    pi_lvl <= 3'd0;
                end
            endcase
        end
    end

    assign pi_req = (state == PI_REQ);

    // CONI PI word assembled purely from registered state
    always_comb begin
        coni_pi = '0;
        coni_pi[CONI_TIMEOUT] = pi_timeout;
        coni_pi[CONI_ON]      = sys_on;
        for (int l = 1; l <= 7; l++) begin
            coni_pi[CONI_PROG_BASE + l] = prog[l];
            coni_pi[CONI_HELD_BASE + l] = held[l];
            coni_pi[CONI_ACT_BASE + l]  = active[l];
        end
    end

endmodule

// File: tb/tb_pi_arb.sv
// Testbench for pi_arb: directed scenarios followed by randomized traffic
// checked cycle by cycle against a behavioural model of the PI system.
module tb_pi_arb;

    localparam int ACK_TIMEOUT = 15;

    logic         clk;
    logic         RESET;
    logic         apr_interrupt;
    logic [2:0]   apr_pia;
    logic [1:7]   dev_req;
    logic         cono_pi;
    logic [18:35] ebus_data;
    logic         pi_ack;
    logic         pi_dismiss;
    logic         pi_req;
    logic [2:0]   pi_lvl;
    logic         pi_timeout;
    logic [0:35]  coni_pi;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Behavioural model state; level arrays use indices 1..7
    bit       m_on;
    bit [7:0] m_act;
    bit [7:0] m_held;
    bit [7:0] m_prog;
    bit       m_busy;
    int       m_lvl;
    int       m_cnt;
    bit       m_to;

    pi_arb #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk           (clk),
        .RESET         (RESET),
        .apr_interrupt (apr_interrupt),
        .apr_pia       (apr_pia),
        .dev_req       (dev_req),
        .cono_pi       (cono_pi),
        .ebus_data     (ebus_data),
        .pi_ack        (pi_ack),
        .pi_dismiss    (pi_dismiss),
        .pi_req        (pi_req),
        .pi_lvl        (pi_lvl),
        .pi_timeout    (pi_timeout),
        .coni_pi       (coni_pi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_on = 0; m_act = '0; m_held = '0; m_prog = '0;
        m_busy = 0; m_lvl = 0; m_cnt = 0; m_to = 0;
    endtask

    // One clock of the PI system as described by its rules
    task automatic model_step();
        bit [7:0] elig;
        bit [7:0] lmask;
        bit       seen_held;
        int       win;
        bit       n_on;
        bit [7:0] n_act;
        bit [7:0] n_prog;
        bit [7:0] n_held;
        if (RESET || (cono_pi && ebus_data[23])) begin
            model_clear();
            return;
        end
        elig = '0;
        seen_held = 0;
        for (int l = 1; l <= 7; l++) begin
            bit r;
            r = dev_req[l] || m_prog[l] || (apr_interrupt && apr_pia == l);
            if (m_held[l]) seen_held = 1;
            elig[l] = m_on && m_act[l] && r && !seen_held;
        end
        win = 0;
        for (int l = 1; l <= 7; l++) if (elig[l] && win == 0) win = l;

        n_on = m_on; n_act = m_act; n_prog = m_prog;
        if (cono_pi) begin
            lmask = '0;
            for (int l = 1; l <= 7; l++) lmask[l] = ebus_data[28 + l];
            if (ebus_data[24]) n_prog = n_prog | lmask;
            if (ebus_data[22]) n_prog = n_prog & ~lmask;
            if (ebus_data[25]) n_act = n_act | lmask;
            if (ebus_data[26]) n_act = n_act & ~lmask;
            if (ebus_data[28]) n_on = 1;
            if (ebus_data[27]) n_on = 0;
        end

        n_held = m_held;
        if (pi_dismiss) begin
            for (int l = 1; l <= 7; l++) begin
                if (m_held[l]) begin
                    n_held[l] = 0;
                    break;
                end
            end
        end
        if (m_busy && pi_ack) n_held[m_lvl] = 1;

        if (!m_busy) begin
            if (win != 0) begin
                m_busy = 1; m_lvl = win; m_cnt = 0;
            end
        end else if (pi_ack) begin
            m_busy = 0; m_lvl = 0;
        end else if (!n_on || !n_act[m_lvl]) begin
            m_busy = 0; m_lvl = 0;
        end else if (m_cnt == ACK_TIMEOUT - 1) begin
            m_busy = 0; m_lvl = 0; m_to = 1;
        end else begin
            m_cnt++;
        end
        m_on = n_on; m_act = n_act; m_prog = n_prog; m_held = n_held;
    endtask

    // Advance one clock, step the model, then release one-cycle strobes
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        RESET = 0;
        cono_pi = 0;
        pi_ack = 0;
        pi_dismiss = 0;
    endtask

    task automatic cono(input logic [17:0] word);
        cono_pi = 1;
        ebus_data = word;
        tick();
        ebus_data = '0;
    endtask

    task automatic test_reset();
        RESET = 1;
        tick();
        tot_cnt++;
        if (pi_req !== 1'b0 || pi_lvl !== 3'd0 || pi_timeout !== 1'b0 || coni_pi !== 36'd0)
            $display("FAIL reset: req=%b lvl=%0d to=%b coni=%o, want all zero",
                     pi_req, pi_lvl, pi_timeout, coni_pi);
        else pass_cnt++;
    endtask

    task automatic test_basic_grant();
        cono(18'o002377);
        tot_cnt++;
        if (coni_pi[28:35] !== 8'hFF)
            $display("FAIL cono_on_active: coni[28:35]=%b want 11111111", coni_pi[28:35]);
        else pass_cnt++;
        dev_req = 7'b0010000;
        tick();
        tot_cnt++;
        if (pi_req !== 1'b1 || pi_lvl !== 3'd3)
            $display("FAIL grant_lvl3: req=%b lvl=%0d want req=1 lvl=3", pi_req, pi_lvl);
        else pass_cnt++;
        pi_ack = 1;
        tick();
        tot_cnt++;
        if (pi_req !== 1'b0 || coni_pi[21:27] !== 7'b0010000)
            $display("FAIL ack_lvl3: req=%b held=%b want req=0 held=0010000", pi_req, coni_pi[21:27]);
        else pass_cnt++;
    endtask

    task automatic test_held_dismiss();
        dev_req = 7'b0010100;
        tick();
        tick();
        tot_cnt++;
        if (pi_req !== 1'b0)
            $display("FAIL held_blocks_lower: req=%b want 0", pi_req);
        else pass_cnt++;
        dev_req = 7'b0110100;
        tick();
        tot_cnt++;
        if (pi_req !== 1'b1 || pi_lvl !== 3'd2)
            $display("FAIL higher_over_held: req=%b lvl=%0d want req=1 lvl=2", pi_req, pi_lvl);
        else pass_cnt++;
        pi_ack = 1;
        tick();
        dev_req = '0;
        pi_dismiss = 1;
        tick();
        tot_cnt++;
        if (coni_pi[21:27] !== 7'b0010000)
            $display("FAIL dismiss_first: held=%b want 0010000", coni_pi[21:27]);
        else pass_cnt++;
        pi_dismiss = 1;
        tick();
        tot_cnt++;
        if (coni_pi[21:27] !== 7'b0000000 || pi_req !== 1'b0)
            $display("FAIL dismiss_second: held=%b req=%b want 0000000 0", coni_pi[21:27], pi_req);
        else pass_cnt++;
    endtask

    task automatic test_apr();
        apr_pia = 3'd4;
        apr_interrupt = 1;
        tick();
        tot_cnt++;
        if (pi_req !== 1'b1 || pi_lvl !== 3'd4)
            $display("FAIL apr_lvl4: req=%b lvl=%0d want req=1 lvl=4", pi_req, pi_lvl);
        else pass_cnt++;
        pi_ack = 1;
        tick();
        apr_interrupt = 0;
        pi_dismiss = 1;
        tick();
        apr_pia = 3'd0;
        apr_interrupt = 1;
        tick();
        tick();
        tot_cnt++;
        if (pi_req !== 1'b0 || coni_pi[21:27] !== 7'b0)
            $display("FAIL apr_disabled: req=%b held=%b want 0 0000000", pi_req, coni_pi[21:27]);
        else pass_cnt++;
        apr_interrupt = 0;
    endtask

    task automatic test_timeout();
        int  high;
        bit  dropped;
        dev_req = 7'b0000010;
        tick();
        high = 0;
        dropped = 0;
        for (int i = 0; i < 20; i++) begin
            if (pi_req !== 1'b1) begin
                dropped = 1;
                break;
            end
            high++;
            if (high == ACK_TIMEOUT) dev_req = '0;
            tick();
        end
        dev_req = '0;
        tot_cnt++;
        if (!dropped || high != ACK_TIMEOUT)
            $display("FAIL timeout_len: high_cycles=%0d dropped=%0d want %0d 1", high, dropped, ACK_TIMEOUT);
        else pass_cnt++;
        tot_cnt++;
        if (pi_timeout !== 1'b1 || coni_pi[0] !== 1'b1)
            $display("FAIL timeout_flag: to=%b coni0=%b want 1 1", pi_timeout, coni_pi[0]);
        else pass_cnt++;
        cono(18'o010000);
        tot_cnt++;
        if (pi_timeout !== 1'b0 || coni_pi !== 36'd0 || pi_req !== 1'b0)
            $display("FAIL cono_clear: to=%b coni=%o req=%b want 0 0 0", pi_timeout, coni_pi, pi_req);
        else pass_cnt++;
    endtask

    task automatic test_sysoff_ack_dismiss();
        cono(18'o002377);
        dev_req = 7'b0000100;
        tick();
        pi_ack = 1;
        tick();
        dev_req = 7'b1000000;
        tick();
        tot_cnt++;
        if (pi_req !== 1'b1 || pi_lvl !== 3'd1)
            $display("FAIL lvl1_over_held5: req=%b lvl=%0d want 1 1", pi_req, pi_lvl);
        else pass_cnt++;
        cono(18'o000400);
        tot_cnt++;
        if (pi_req !== 1'b0 || pi_timeout !== 1'b0 || pi_lvl !== 3'd0)
            $display("FAIL sys_off_abort: req=%b to=%b lvl=%0d want 0 0 0", pi_req, pi_timeout, pi_lvl);
        else pass_cnt++;
        cono(18'o000200);
        tick();
        tot_cnt++;
        if (pi_req !== 1'b1 || pi_lvl !== 3'd1)
            $display("FAIL sys_on_rereq: req=%b lvl=%0d want 1 1", pi_req, pi_lvl);
        else pass_cnt++;
        dev_req = '0;
        pi_ack = 1;
        pi_dismiss = 1;
        tick();
        tot_cnt++;
        if (coni_pi[21:27] !== 7'b1000000)
            $display("FAIL ack_and_dismiss: held=%b want 1000000", coni_pi[21:27]);
        else pass_cnt++;
        pi_dismiss = 1;
        tick();
    endtask

    task automatic test_reset_mid_and_lvl_off();
        dev_req = 7'b0100000;
        tick();
        RESET = 1;
        tick();
        dev_req = '0;
        tot_cnt++;
        if (pi_req !== 1'b0 || pi_lvl !== 3'd0 || pi_timeout !== 1'b0 || coni_pi !== 36'd0)
            $display("FAIL reset_mid_req: req=%b lvl=%0d to=%b coni=%o want all zero",
                     pi_req, pi_lvl, pi_timeout, coni_pi);
        else pass_cnt++;
        cono(18'o002377);
        cono(18'o003020);
        tot_cnt++;
        if (coni_pi[28:35] !== 8'b11101111)
            $display("FAIL lvl_on_off_same: coni[28:35]=%b want 11101111", coni_pi[28:35]);
        else pass_cnt++;
        dev_req = 7'b0010000;
        tick();
        tick();
        tot_cnt++;
        if (pi_req !== 1'b0)
            $display("FAIL inactive_lvl_req: req=%b want 0", pi_req);
        else pass_cnt++;
        dev_req = '0;
    endtask

    task automatic test_random();
        logic [0:35] ec;
        RESET = 1;
        tick();
        cono(18'o002377);
        for (int n = 0; n < 3000; n++) begin
            int ack_pct;
            ack_pct = (n < 1500) ? 30 : 3;
            for (int l = 1; l <= 7; l++) dev_req[l] = ($urandom_range(0, 7) == 0);
            apr_interrupt = ($urandom_range(0, 5) == 0);
            apr_pia = 3'($urandom_range(0, 7));
            pi_ack = ($urandom_range(0, 99) < ack_pct);
            pi_dismiss = ($urandom_range(0, 9) == 0);
            RESET = ($urandom_range(0, 299) == 0);
            cono_pi = ($urandom_range(0, 29) == 0);
            ebus_data = 18'($urandom);
            if ($urandom_range(0, 7) != 0) ebus_data[23] = 1'b0;
            if (ebus_data[22] && ebus_data[24]) ebus_data[22] = 1'b0;
            if ($urandom_range(0, 1) == 0) begin
                ebus_data[25] = 1'b1;
                ebus_data[28] = 1'b1;
                ebus_data[27] = 1'b0;
            end
            tick();
            ec = '0;
            ec[0] = m_to;
            ec[28] = m_on;
            for (int l = 1; l <= 7; l++) begin
                ec[10 + l] = m_prog[l];
                ec[20 + l] = m_held[l];
                ec[28 + l] = m_act[l];
            end
            tot_cnt++;
            if (pi_req !== m_busy || pi_lvl !== 3'(m_lvl) || pi_timeout !== m_to || coni_pi !== ec)
                $display("FAIL random_cycle%0d: req=%b lvl=%0d to=%b coni=%o want req=%b lvl=%0d to=%b coni=%o",
                         n, pi_req, pi_lvl, pi_timeout, coni_pi, m_busy, m_lvl, m_to, ec);
            else pass_cnt++;
        end
    endtask

    initial begin
        RESET = 1;
        apr_interrupt = 0;
        apr_pia = '0;
        dev_req = '0;
        cono_pi = 0;
        ebus_data = '0;
        pi_ack = 0;
        pi_dismiss = 0;
        model_clear();
        test_reset();
        test_basic_grant();
        test_held_dismiss();
        test_apr();
        test_timeout();
        test_sysoff_ack_dismiss();
        test_reset_mid_and_lvl_off();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
